// File: rtl/l2req_arbiter_rr_pkg.sv
// Shared types and constants for the core->L2 request path.
package l2req_arbiter_rr_pkg;

    // One L2 request beat; .valid marks an occupied slot / pending request.
    typedef struct packed {
        logic        valid;
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [7:0]  tag;
    } l2req_packet_t;

    localparam int L2REQ_PKT_W = $bits(l2req_packet_t);

    localparam int L2REQ_UNIT_ICACHE = 0;
    localparam int L2REQ_UNIT_DCACHE = 1;
    localparam int L2REQ_UNIT_STBUF  = 2;

    // Index width that stays at least one bit wide for the single-requester case.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/l2req_arbiter_rr_priority_picker.sv
// Combinational rotating-priority picker: first set request bit at or after
// ptr, wrapping around. ptr = 0 gives plain lowest-index-first priority.
module rr_priority_picker
    import l2req_arbiter_rr_pkg::*;
#(
    parameter  int WIDTH = 3,
    localparam int IW    = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [WIDTH-1:0] gnt,
    output logic [IW-1:0]    gnt_idx,
    output logic             any
);

    // Two passes: indices at/above the pointer first, then the wrapped-around ones.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!any && req[i] && (IW'(i) >= ptr)) begin
                any     = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = IW'(i);
            end
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (!any && req[i]) begin
                any     = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/l2req_arbiter_rr.sv
// N-way arbiter merging per-unit L2 request streams into one registered
// request slot, with round-robin or fixed priority plus a starvation guard.
module l2req_arbiter_rr
    import l2req_arbiter_rr_pkg::*;
#(
    parameter  int NUM_REQUESTERS = 3,
    parameter  bit ROUND_ROBIN    = 1'b1,
    parameter  int MAX_WAIT       = 15,
    localparam int IW             = idx_width(NUM_REQUESTERS),
    localparam int CW             = $clog2(MAX_WAIT + 1)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  l2req_packet_t [NUM_REQUESTERS-1:0]   unit_packet_i,
    output logic [NUM_REQUESTERS-1:0]            unit_ready_o,
    input  logic                                 l2req_ready,
    output l2req_packet_t                        l2req_packet,
    output logic [IW-1:0]                        grant_index_o
);

    logic [NUM_REQUESTERS-1:0] req;
    logic [NUM_REQUESTERS-1:0] sat;
    logic [IW-1:0]             rr_ptr;
    logic [IW-1:0]             pick_ptr;
    logic [NUM_REQUESTERS-1:0] main_gnt, sat_gnt, win_gnt;
    logic [IW-1:0]             main_idx, sat_idx, win_idx;
    logic                      main_any, sat_any, win_any;
    logic                      slot_free;
    logic [CW-1:0]             wait_cnt [NUM_REQUESTERS];

    assign slot_free = !l2req_packet.valid || l2req_ready;
    assign pick_ptr  = ROUND_ROBIN ? rr_ptr : '0;

    // Pending requests, and the subset whose wait counter has saturated.
    always_comb begin
        req = '0;
        sat = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            req[i] = unit_packet_i[i].valid;
            sat[i] = unit_packet_i[i].valid && (wait_cnt[i] == CW'(MAX_WAIT));
        end
    end

    rr_priority_picker #(.WIDTH(NUM_REQUESTERS)) u_pick_main (
        .req     (req),
        .ptr     (pick_ptr),
        .gnt     (main_gnt),
        .gnt_idx (main_idx),
        .any     (main_any)
    );

    rr_priority_picker #(.WIDTH(NUM_REQUESTERS)) u_pick_sat (
        .req     (sat),
        .ptr     ('0),
        .gnt     (sat_gnt),
        .gnt_idx (sat_idx),
        .any     (sat_any)
    );

    // Starved units override the normal order in fixed-priority mode only.
    always_comb begin
        win_gnt = main_gnt;
        win_idx = main_idx;
        win_any = main_any;
        if (!ROUND_ROBIN && sat_any) begin
            win_gnt = sat_gnt;
            win_idx = sat_idx;
            win_any = 1'b1;
        end
    end

    // Accept is combinational so the slot can be refilled in the handshake cycle.
    always_comb begin
        unit_ready_o = '0;
        if (slot_free && !reset) begin
            unit_ready_o = win_gnt;
        end
    end

    // Output slot: load the winner when free, otherwise hold the packet untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l2req_packet  <= '0;
            grant_index_o <= '0;
        end else if (slot_free) begin
            if (win_any) begin
                l2req_packet  <= unit_packet_i[win_idx];
                grant_index_o <= win_idx;
            end else begin
                l2req_packet  <= '0;
            end
        end
    end

    // Round-robin pointer moves just past the last winner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (slot_free && win_any) begin
            rr_ptr <= (win_idx == IW'(NUM_REQUESTERS - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    // Per-unit lost-arbitration counters; idle in round-robin mode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQUESTERS; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQUESTERS; i++) begin
                if (ROUND_ROBIN || !req[i] || (slot_free && win_gnt[i])) begin
                    wait_cnt[i] <= '0;
                end else if (slot_free && (wait_cnt[i] != CW'(MAX_WAIT))) begin
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_l2req_arbiter_rr.sv
// Directed and random checks of l2req_arbiter_rr against a reference model and
// an in-order scoreboard of accepted packets.
module tb_l2req_arbiter_rr;
    import l2req_arbiter_rr_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic l2req_ready = 1'b0;
    always #5 clk = ~clk;

    l2req_packet_t up [8];

    logic [2:0]    rdy_rr3, rdy_fp3;
    logic [4:0]    rdy_rr5;
    l2req_packet_t pkt_rr3, pkt_fp3, pkt_rr5;
    logic [1:0]    gi_rr3, gi_fp3;
    logic [2:0]    gi_rr5;

    l2req_arbiter_rr #(.NUM_REQUESTERS(3), .ROUND_ROBIN(1'b1), .MAX_WAIT(15)) dut_rr3 (
        .clk(clk), .reset(reset), .unit_packet_i({up[2], up[1], up[0]}),
        .unit_ready_o(rdy_rr3), .l2req_ready(l2req_ready),
        .l2req_packet(pkt_rr3), .grant_index_o(gi_rr3));

    l2req_arbiter_rr #(.NUM_REQUESTERS(3), .ROUND_ROBIN(1'b0), .MAX_WAIT(4)) dut_fp3 (
        .clk(clk), .reset(reset), .unit_packet_i({up[2], up[1], up[0]}),
        .unit_ready_o(rdy_fp3), .l2req_ready(l2req_ready),
        .l2req_packet(pkt_fp3), .grant_index_o(gi_fp3));

    l2req_arbiter_rr #(.NUM_REQUESTERS(5), .ROUND_ROBIN(1'b1), .MAX_WAIT(15)) dut_rr5 (
        .clk(clk), .reset(reset), .unit_packet_i({up[4], up[3], up[2], up[1], up[0]}),
        .unit_ready_o(rdy_rr5), .l2req_ready(l2req_ready),
        .l2req_packet(pkt_rr5), .grant_index_o(gi_rr5));

    int            inst;
    logic [7:0]    obs_rdy;
    l2req_packet_t obs_pkt;
    logic [2:0]    obs_gi;

    always_comb begin
        obs_rdy = '0;
        obs_pkt = '0;
        obs_gi  = '0;
        case (inst)
            0:       begin obs_rdy = {5'd0, rdy_rr3}; obs_pkt = pkt_rr3; obs_gi = {1'b0, gi_rr3}; end
            1:       begin obs_rdy = {5'd0, rdy_fp3}; obs_pkt = pkt_fp3; obs_gi = {1'b0, gi_fp3}; end
            default: begin obs_rdy = {3'd0, rdy_rr5}; obs_pkt = pkt_rr5; obs_gi = gi_rr5; end
        endcase
    end

    int            total, bad;
    int            mn, mmax;
    bit            mrr;
    bit            m_valid;
    int            m_gi, m_ptr;
    int            mw [8];
    int            mwaitg [8];
    l2req_packet_t q [$];
    int            last_win;
    logic [7:0]    last_rdy;
    bit            refill;
    int            seq;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pk64(input l2req_packet_t p);
        return {{(64 - L2REQ_PKT_W){1'b0}}, p};
    endfunction

    function automatic l2req_packet_t mk_pkt(input int u);
        l2req_packet_t p;
        seq++;
        p.valid = 1'b1;
        p.cmd   = 2'(u);
        p.addr  = {8'(u), 24'(seq)};
        p.tag   = 8'(seq);
        return p;
    endfunction

    task automatic model_clear();
        m_valid = 1'b0;
        m_ptr   = 0;
        m_gi    = 0;
        q.delete();
        for (int k = 0; k < 8; k++) begin
            mw[k]     = 0;
            mwaitg[k] = 0;
        end
    endtask

    task automatic set_mode(input int i, input int n, input bit rr, input int mx);
        inst = i;
        mn   = n;
        mrr  = rr;
        mmax = mx;
    endtask

    // Called at a falling edge: async reset, check cleared outputs, release.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_valid", 64'(obs_pkt.valid), 64'd0);
        chk("rst_ready", 64'(obs_rdy), 64'd0);
        chk("rst_gidx",  64'(obs_gi), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    // One cycle: inputs are already driven; compare, update the model, clock.
    task automatic step();
        int         win;
        bit         free;
        logic [7:0] exp_rdy;
        #1;
        free = !m_valid || l2req_ready;
        win  = -1;
        if (free) begin
            if (mrr) begin
                for (int k = 0; k < mn; k++) begin
                    int c;
                    c = (m_ptr + k) % mn;
                    if (win < 0 && up[c].valid) win = c;
                end
            end else begin
                for (int k = 0; k < mn; k++)
                    if (win < 0 && up[k].valid && mw[k] == mmax) win = k;
                for (int k = 0; k < mn; k++)
                    if (win < 0 && up[k].valid) win = k;
            end
        end
        exp_rdy = (win >= 0) ? 8'(1 << win) : 8'd0;
        last_rdy = obs_rdy;
        chk("unit_ready", 64'(obs_rdy), 64'(exp_rdy));
        chk("slot_valid", 64'(obs_pkt.valid), 64'(m_valid));
        if (m_valid) begin
            chk("grant_index", 64'(obs_gi), 64'(m_gi));
            if (q.size() == 0) chk("sb_nonempty", 64'(q.size()), 64'd1);
            else if (l2req_ready) chk("l2_packet", pk64(obs_pkt), pk64(q.pop_front()));
            else chk("held_packet", pk64(obs_pkt), pk64(q[0]));
        end
        for (int k = 0; k < mn; k++) begin
            if (!up[k].valid) begin
                mw[k]     = 0;
                mwaitg[k] = 0;
            end else if (k == win) begin
                if (mrr) chk("rr_fair", 64'(mwaitg[k] <= mn - 1), 64'd1);
                mw[k]     = 0;
                mwaitg[k] = 0;
            end else if (free) begin
                if (win >= 0) mwaitg[k]++;
                if (mw[k] < mmax) mw[k]++;
            end
        end
        last_win = win;
        if (win >= 0) begin
            q.push_back(up[win]);
            m_gi    = win;
            m_ptr   = (win + 1) % mn;
            m_valid = 1'b1;
        end else if (free) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        if (win >= 0) begin
            if (refill) up[win] = mk_pkt(win);
            else up[win].valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic clear_units();
        for (int k = 0; k < 8; k++) up[k] = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int exp_t3 [8];
        int guard;
        bit busy;
        total = 0;
        bad   = 0;
        seq   = 0;
        refill = 1'b0;
        clear_units();
        model_clear();
        set_mode(0, 3, 1'b1, 15);
        @(negedge clk);
        do_reset();

        // 1: continuous round robin, full throughput
        l2req_ready = 1'b1;
        refill = 1'b1;
        for (int k = 0; k < 3; k++) up[k] = mk_pkt(k);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("t1_grant", 64'(last_rdy), 64'(1 << (k % 3)));
        end
        clear_units();
        step();
        step();

        // 2: backpressure, single pulse then held slot
        do_reset();
        refill = 1'b0;
        l2req_ready = 1'b0;
        up[1] = mk_pkt(1);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (last_rdy[1]) pulses++;
        end
        chk("t2_pulses", 64'(pulses), 64'd1);
        l2req_ready = 1'b1;
        step();
        step();
        chk("t2_cleared", 64'(obs_pkt.valid), 64'd0);

        // 4: pointer wrap
        do_reset();
        up[1] = mk_pkt(1);
        step();
        chk("t4_first", 64'(last_rdy), 64'd2);
        up[0] = mk_pkt(0);
        step();
        chk("t4_wrap", 64'(last_rdy), 64'd1);
        up[0] = mk_pkt(0);
        up[1] = mk_pkt(1);
        step();
        chk("t4_after_wrap", 64'(last_rdy), 64'd2);
        step();
        clear_units();
        step();

        // 5: reset while a packet is held under backpressure
        do_reset();
        up[1] = mk_pkt(1);
        step();
        l2req_ready = 1'b0;
        up[2] = mk_pkt(2);
        step();
        chk("t5_held_before_rst", 64'(obs_pkt.valid), 64'd1);
        do_reset();
        up[1] = mk_pkt(1);
        l2req_ready = 1'b1;
        step();
        chk("t5_first_after_rst", 64'(last_rdy), 64'd2);
        clear_units();
        step();

        // 3: fixed priority with starvation guard
        set_mode(1, 3, 1'b0, 4);
        do_reset();
        exp_t3 = '{0, 0, 0, 0, 2, 0, 0, 0};
        refill = 1'b1;
        up[0] = mk_pkt(0);
        up[2] = mk_pkt(2);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t3_grant", 64'(last_rdy), 64'(1 << exp_t3[k]));
        end
        clear_units();
        step();
        step();

        // 6: random stress, five requesters
        set_mode(2, 5, 1'b1, 15);
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int u = 0; u < 5; u++)
                if (!up[u].valid && $urandom_range(0, 2) == 0) up[u] = mk_pkt(u);
            l2req_ready = ($urandom_range(0, 3) != 0);
            refill = ($urandom_range(0, 1) == 1);
            step();
        end
        refill = 1'b0;
        l2req_ready = 1'b1;
        guard = 0;
        busy = 1'b1;
        while (busy && guard < 40) begin
            step();
            guard++;
            busy = m_valid;
            for (int u = 0; u < 5; u++) if (up[u].valid) busy = 1'b1;
        end
        chk("t6_drained", 64'(busy), 64'd0);
        chk("t6_sb_empty", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
